interval_timer: RTL and testbench
=================================

// Module: interval_timer
// PURPOSE
//  Programmable countdown resource for the traffic-light controller FSM. It holds the three light
//  intervals: base, extended and yellow. On start_timer it loads the interval chosen by
//  interval_address and counts it down in 1-second ticks from an internal clock divider. It then
//  pulses expired back to the FSM. Interval values are reprogrammed through the synchronised
//  prg_sync_in strobe.
// PARAMETERS
//  CLK_DIV    50_000_000  clk cycles per 1-second tick (bench uses 4)
//  VAL_W      4           interval width in seconds
//  TBASE_DEF  6           reset value of base interval
//  TEXT_DEF   3           reset value of extended interval
//  TYEL_DEF   2           reset value of yellow interval
// PORTS
//  clk               in   1      system clock, single clock domain
//  sys_reset         in   1      synchronous, active-high reset
//  start_timer       in   1      1-cycle request: load interval[interval_address] and start countdown
//  interval_address  in   2      00 base, 01 extended, 10 yellow, 11 treated as base
//  prg_sync_in       in   1      1-cycle program strobe, already synchronised
//  prg_sel           in   2      register to program: 00 base, 01 extended, 10 yellow, 11 ignored
//  prg_value         in   VAL_W  new interval value in seconds
//  expired           out  1      1-cycle pulse when the countdown completes
//  busy              out  1      high while counting
//  remaining         out  VAL_W  seconds left; 0 when idle
// BEHAVIOUR
//  Reset (sys_reset=1 at an edge)
//   - Intervals return to their *_DEF values. State=IDLE, divider=0, remaining=0, expired=0, busy=0.
//   - Reset overrides every other input and aborts any count in progress.
//  States: IDLE, COUNT, EXPIRE. expired=(state==EXPIRE); busy=(state==COUNT). Both are registered.
//  IDLE -> COUNT on start_timer
//   - remaining<=interval[addr]; divider<=0.
//  COUNT
//   - divider increments each cycle.
//   - When divider==CLK_DIV-1: tick; divider<=0; remaining decrements.
//   - A tick with remaining==1 sets remaining<=0 and moves to EXPIRE.
//  EXPIRE lasts exactly 1 cycle
//   - Then IDLE, or COUNT if start_timer is high in that cycle (reload as above).
//  Latency: expired is high in the cycle exactly value*CLK_DIV edges after the edge that sampled
//   start_timer. It is never held longer than 1 cycle.
//  start_timer while in COUNT: restart with a fresh load and divider cleared. Restart wins over a
//   final tick in the same cycle, so no expired is produced.
//  prg_sync_in:
//   - Writes prg_value to the register selected by prg_sel; prg_sel=11 is a no-op write.
//   - prg_value==0 is stored as 1.
//   - Any in-progress count is aborted: state<=IDLE, remaining<=0, no expired.
//  prg_sync_in and start_timer in the same cycle: programming has priority and start is discarded.
//  A new value affects only loads after the write edge. A running count keeps its loaded value
//   unless it is aborted.
//  No wrap-around: remaining never decrements below 0, and the divider restarts on every load.
// STRUCTURE
//  tl_pkg (shared package):
//   - Interval address constants ADDR_BASE/ADDR_EXT/ADDR_YEL.
//   - Default interval constants.
//   - State encoding typedef, reused by the light FSM.
//  Sub-module tick_divider(clk, sys_reset, clear, en, tick):
//   - Counts 0..CLK_DIV-1 while en is high; tick is a 1-cycle pulse on the terminal count.
//   - clear has priority over counting.
//  Interval register file and state machine are inline in interval_timer.
// TESTING (CLK_DIV=4)
//  1. Reset, then start_timer with addr=00 -> busy=1, remaining=6; expired is a single-cycle pulse
//     24 cycles after start; busy=0 and remaining=0 afterwards.
//  2. prg_sync_in with sel=01, value=5, then start with addr=01 -> expired after exactly 20 cycles.
//  3. Start with addr=10 (2 s), restart with addr=00 at cycle 5 -> no expired at cycle 8;
//     expired 24 cycles after the second start.
//  4. Start with addr=00, prg_sync_in at cycle 10 -> busy=0, remaining=0, expired never
//     asserts; base interval reads back the new value on the next load.
//  5. prg value=0 with sel=10 -> a yellow load expires after 4 cycles. sel=11 with value=9 ->
//     all intervals unchanged. prg_sync_in and start in the same cycle -> no count starts.
//  6. sys_reset asserted mid-count after base was reprogrammed to 9 -> all outputs 0; the next
//     start with addr=00 expires after 24 cycles (default restored).

Source files
------------

// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: interval addresses, default intervals, and the state encoding.
package tl_pkg;

    localparam logic [1:0] ADDR_BASE = 2'b00;
    localparam logic [1:0] ADDR_EXT  = 2'b01;
    localparam logic [1:0] ADDR_YEL  = 2'b10;

    localparam int DEF_TBASE = 6;
    localparam int DEF_TEXT  = 3;
    localparam int DEF_TYEL  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_EXPIRE = 2'd2
    } tl_state_e;

    // Address 11 is not a real register and falls back to the base interval.
    function automatic logic [1:0] intv_index(input logic [1:0] addr);
        return (addr == 2'b11) ? ADDR_BASE : addr;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Clock divider: 1-cycle tick on terminal count CLK_DIV-1 while en is high; clear wins over counting.
// Latency: tick is combinational from the count register; no backpressure.
module tick_divider #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable base/extended/yellow countdown; expired pulses value*CLK_DIV cycles after start.
// No backpressure: programming aborts any count and beats a same-cycle start; restart beats a final tick.
module interval_timer
    import tl_pkg::*;
#(
    parameter int CLK_DIV   = 50_000_000,
    parameter int VAL_W     = 4,
    parameter int TBASE_DEF = DEF_TBASE,
    parameter int TEXT_DEF  = DEF_TEXT,
    parameter int TYEL_DEF  = DEF_TYEL
) (
    input  logic             clk,
    input  logic             sys_reset,
    input  logic             start_timer,
    input  logic [1:0]       interval_address,
    input  logic             prg_sync_in,
    input  logic [1:0]       prg_sel,
    input  logic [VAL_W-1:0] prg_value,
    output logic             expired,
    output logic             busy,
    output logic [VAL_W-1:0] remaining
);

    tl_state_e        state_q;
    tl_state_e        state_d;
    logic [VAL_W-1:0] remaining_q;
    logic [VAL_W-1:0] remaining_d;
    logic [VAL_W-1:0] intv_q [0:2];
    logic [VAL_W-1:0] intv_d [0:2];
    logic [VAL_W-1:0] load_val;
    logic             div_clear;
    logic             div_en;
    logic             tick;

    assign load_val = intv_q[intv_index(interval_address)];
    assign div_en   = (state_q == ST_COUNT);

    tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk       (clk),
        .sys_reset (sys_reset),
        .clear     (div_clear),
        .en        (div_en),
        .tick      (tick)
    );

    // A zero interval would never expire cleanly, so it is stored as one second.
    always_comb begin
        intv_d = intv_q;
        if (prg_sync_in && (prg_sel != 2'b11)) begin
            intv_d[prg_sel] = (prg_value == '0) ? VAL_W'(1) : prg_value;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            intv_q[0]   <= VAL_W'(TBASE_DEF);
            intv_q[1]   <= VAL_W'(TEXT_DEF);
            intv_q[2]   <= VAL_W'(TYEL_DEF);
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            intv_q      <= intv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        div_clear   = 1'b0;
        if (prg_sync_in) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            div_clear   = 1'b1;
        end else if (start_timer) begin
            state_d     = ST_COUNT;
            remaining_d = load_val;
            div_clear   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_COUNT: begin
                    if (tick) begin
                        if (remaining_q <= VAL_W'(1)) begin
                            remaining_d = '0;
                            state_d     = ST_EXPIRE;
                        end else begin
                            remaining_d = remaining_q - VAL_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        expired   = (state_q == ST_EXPIRE);
        busy      = (state_q == ST_COUNT);
        remaining = remaining_q;
    end

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboarded bench for interval_timer at CLK_DIV=4: directed scenarios then random stimulus
// against a deadline-based reference model.
module tb_interval_timer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       sys_reset = 1'b0;
    logic       start_timer = 1'b0;
    logic [1:0] interval_address = 2'b00;
    logic       prg_sync_in = 1'b0;
    logic [1:0] prg_sel = 2'b00;
    logic [3:0] prg_value = 4'd0;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;

    interval_timer #(
        .CLK_DIV (DIV),
        .VAL_W   (4)
    ) dut (
        .clk              (clk),
        .sys_reset        (sys_reset),
        .start_timer      (start_timer),
        .interval_address (interval_address),
        .prg_sync_in      (prg_sync_in),
        .prg_sel          (prg_sel),
        .prg_value        (prg_value),
        .expired          (expired),
        .busy             (busy),
        .remaining        (remaining)
    );

    always #5 clk = ~clk;

    // Reference model: a count is just (start edge, loaded seconds, deadline edge).
    int intv [3] = '{6, 3, 2};
    bit active = 1'b0;
    int start_c = 0;
    int lv = 0;
    int dl = 0;
    int exp_q [$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic abort_count(input int n);
        if (active && dl >= n && exp_q.size() > 0) void'(exp_q.pop_back());
        active = 1'b0;
    endtask

    task automatic model_edge();
        int n;
        int a;
        n = cyc;
        if (sys_reset) begin
            abort_count(n);
            intv = '{6, 3, 2};
        end else if (prg_sync_in) begin
            abort_count(n);
            if (prg_sel != 2'b11) intv[prg_sel] = (prg_value == 4'd0) ? 1 : int'(prg_value);
        end else if (start_timer) begin
            abort_count(n);
            a = (interval_address == 2'b11) ? 0 : int'(interval_address);
            lv = intv[a];
            start_c = n;
            dl = n + lv * DIV;
            active = 1'b1;
            exp_q.push_back(dl);
        end
    endtask

    task automatic step(input logic st, input logic [1:0] ad, input logic pg,
                        input logic [1:0] sl, input logic [3:0] pv, input logic rs);
        start_timer = st;
        interval_address = ad;
        prg_sync_in = pg;
        prg_sel = sl;
        prg_value = pv;
        sys_reset = rs;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0);
    endtask

    // Monitor: busy/remaining every cycle, expired pulses against the deadline queue.
    int exp_rem;
    bit exp_busy;
    int got_dl;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_busy = active && (cyc >= start_c) && (cyc < dl);
            exp_rem = exp_busy ? lv - (cyc - start_c) / DIV : 0;
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
            end
            checks++;
            if (remaining !== 4'(exp_rem)) begin
                errors++;
                $display("FAIL remaining cyc=%0d got=%0d exp=%0d", cyc, remaining, exp_rem);
            end
            if (expired === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL expired_unexpected cyc=%0d got=1 exp=0", cyc);
                end else begin
                    got_dl = exp_q.pop_front();
                    if (got_dl != cyc) begin
                        errors++;
                        $display("FAIL expired_time got_cyc=%0d exp_cyc=%0d", cyc, got_dl);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
                checks++;
                errors++;
                $display("FAIL expired_missing cyc=%0d got=%b exp_cyc=%0d", cyc, expired, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic st;
        logic pg;
        logic rs;
        // Reset and reset-state checks.
        step(1'b0, 2'b00, 1'b0, 2'b00, 4'd0, 1'b1);
        mon_en = 1'b1;
        idle(2);
        // 1: base interval, 24 cycles.
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(28);
        // 2: extended reprogrammed to 5, 20 cycles.
        step(1'b0, 2'b00, 1'b1, 2'b01, 4'd5, 1'b0);
        step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(24);
        // 3: yellow start, restart with base five cycles later.
        step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(4);
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(28);
        // 4: programming mid-count aborts, next base load uses new value.
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(9);
        step(1'b0, 2'b00, 1'b1, 2'b00, 4'd7, 1'b0);
        idle(5);
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(32);
        // 5: zero stored as one, sel=11 no-op, address 11 maps to base, prg beats start.
        step(1'b0, 2'b00, 1'b1, 2'b10, 4'd0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(6);
        step(1'b0, 2'b00, 1'b1, 2'b11, 4'd9, 1'b0);
        step(1'b1, 2'b11, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(31);
        step(1'b1, 2'b01, 1'b1, 2'b01, 4'd4, 1'b0);
        idle(5);
        step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(20);
        // Start in the expire cycle reloads immediately.
        step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(3);
        step(1'b1, 2'b10, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(6);
        // 6: reset mid-count restores defaults.
        step(1'b0, 2'b00, 1'b1, 2'b00, 4'd9, 1'b0);
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(10);
        step(1'b1, 2'b01, 1'b0, 2'b00, 4'd0, 1'b1);
        idle(3);
        step(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0);
        idle(28);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 29) == 0);
            pg = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(st, 2'($urandom_range(0, 3)), pg, 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), rs);
        end
        idle(70);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expiries got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
